// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between the PS/2 host transmitter and its user,
// plus transfer status and an FSM state tap.
interface ps2_host_tx_if;
    // Valid/ready: the master holds tx_valid with a stable tx_data. The byte is
    // taken on the rising clk edge where tx_valid && tx_ready. tx_valid while
    // tx_ready is low is dropped, not queued.
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_err;
    logic [1:0] err_code;
    logic [2:0] dbg_state;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, tx_done, tx_err, err_code, dbg_state
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, tx_done, tx_err, err_code, dbg_state
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts one
// command byte out on device-generated clock falls and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe,
    ps2_host_tx_if.slave tx
);
    localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS_SETUP, RTS, SEND, ACK_SAMPLE, WAIT_IDLE
    } state_t;

    state_t        state_q;
    logic [2:0]    clk_s_q;
    logic [1:0]    data_s_q;
    logic [9:0]    frame_q;
    logic [3:0]    bit_cnt_q;
    logic [CW-1:0] cnt_q;
    logic          ack_q;
    logic          clk_oe_q;
    logic          data_oe_q;
    logic          done_q;
    logic          err_q;
    logic [1:0]    err_code_q;

    logic fall;
    logic line_clk;
    logic line_data;
    logic timed_out;

    assign fall      = (clk_s_q[2:1] == 2'b10);
    assign line_clk  = clk_s_q[2];
    assign line_data = data_s_q[1];
    assign timed_out = (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            clk_s_q    <= 3'b111;
            data_s_q   <= 2'b11;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            clk_s_q  <= {clk_s_q[1:0], ps2_clk_in};
            data_s_q <= {data_s_q[0], ps2_data_in};
            done_q   <= 1'b0;
            err_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (tx.tx_valid) begin
                        frame_q   <= {1'b1, ~^tx.tx_data, tx.tx_data};
                        cnt_q     <= '0;
                        clk_oe_q  <= 1'b1;
                        data_oe_q <= 1'b0;
                        state_q   <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        // Start bit goes low while the clock is still held.
                        data_oe_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= RTS_SETUP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                RTS_SETUP: begin
                    clk_oe_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= RTS;
                end

                RTS: begin
                    if (fall) begin
                        data_oe_q <= ~frame_q[0];
                        bit_cnt_q <= 4'd1;
                        cnt_q     <= '0;
                        state_q   <= SEND;
                    end else if (timed_out) begin
                        clk_oe_q   <= 1'b0;
                        data_oe_q  <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b01;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                SEND: begin
                    if (fall) begin
                        cnt_q <= '0;
                        if (bit_cnt_q == 4'd10) begin
                            ack_q   <= line_data;
                            state_q <= ACK_SAMPLE;
                        end else begin
                            data_oe_q <= ~frame_q[bit_cnt_q];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else if (timed_out) begin
                        clk_oe_q   <= 1'b0;
                        data_oe_q  <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b01;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ACK_SAMPLE: begin
                    cnt_q <= '0;
                    if (!ack_q) begin
                        state_q <= WAIT_IDLE;
                    end else begin
                        clk_oe_q   <= 1'b0;
                        data_oe_q  <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b10;
                        state_q    <= IDLE;
                    end
                end

                WAIT_IDLE: begin
                    if (line_clk && line_data) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (fall) begin
                        cnt_q <= '0;
                    end else if (timed_out) begin
                        clk_oe_q   <= 1'b0;
                        data_oe_q  <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b01;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_data_oe  = data_oe_q;
    assign tx.tx_ready  = (state_q == IDLE);
    assign tx.busy      = (state_q != IDLE);
    assign tx.tx_done   = done_q;
    assign tx.tx_err    = err_q;
    assign tx.err_code  = err_code_q;
    assign tx.dbg_state = state_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a cycle-level PS/2 device model, directed command
// bytes, and a response scoreboard fed at issue time and drained by a monitor.
module tb_ps2_host_tx;
    localparam int HALF = 20;

    logic clk;
    logic clrn;
    logic ps2_clk_in;
    logic ps2_data_in;
    logic ps2_clk_oe;
    logic ps2_data_oe;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .TIMEOUT_CYCLES(2000)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx         (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- open-drain lines and device model ----------------
    logic        dev_clk_low;
    logic        dev_data_low;
    logic        dev_abort;
    logic        dev_active;
    int          dev_mode;   // 0 = ACK, 1 = silent, 2 = NACK
    int          dev_bits;
    logic [10:0] dev_rx;     // {stop, parity, data[7:0], start}

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    task automatic dev_wait(input int n);
        for (int k = 0; k < n && !dev_abort; k++) @(posedge clk);
    endtask

    initial begin : dev_model
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        dev_active   = 1'b0;
        dev_bits     = 0;
        dev_rx       = '0;
        forever begin
            @(posedge clk);
            if (clrn && !dev_abort && dev_mode != 1 && !ps2_clk_oe && ps2_data_oe) begin
                dev_bits   = 0;
                dev_rx     = '0;
                dev_active = 1'b1;
                dev_wait(10);
                dev_rx[0] = ps2_data_in;
                for (int i = 1; i <= 10 && !dev_abort; i++) begin
                    dev_clk_low = 1'b1;
                    dev_wait(HALF);
                    dev_clk_low = 1'b0;
                    dev_rx[i]   = ps2_data_in;
                    dev_bits    = i;
                    dev_wait(HALF);
                end
                if (!dev_abort) begin
                    if (dev_mode == 0) dev_data_low = 1'b1;
                    dev_wait(5);
                    dev_clk_low = 1'b1;
                    dev_wait(HALF);
                    dev_clk_low = 1'b0;
                    dev_wait(5);
                end
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
                dev_active   = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int          cmp_cnt = 0;
    int          err_cnt = 0;
    logic [13:0] exp_q[$];   // {done, code[1:0], stop, parity, data[7:0], start}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        cmp_cnt++;
        err_cnt++;
        $display("FAIL %s: bounded wait expired, got no event, required one", name);
    endtask

    function automatic logic [13:0] ok_resp(input logic [7:0] b, input logic p);
        return {1'b1, 2'b00, 1'b1, p, b, 1'b0};
    endfunction

    function automatic logic [13:0] err_resp(input logic [1:0] code);
        return {1'b0, code, 11'b0};
    endfunction

    logic [13:0] mon_act;
    logic [13:0] mon_exp;
    logic        prev_done = 1'b0;
    logic        prev_err  = 1'b0;

    always @(negedge clk) begin
        if (clrn) begin
            if (prev_done) check("done_width", bus.tx_done, 1'b0);
            if (prev_err)  check("err_width", bus.tx_err, 1'b0);
            if (bus.tx_done || bus.tx_err) begin
                mon_act = bus.tx_err ? {bus.tx_done, bus.err_code, 11'b0}
                                     : {bus.tx_done, 2'b00, dev_rx};
                if (exp_q.size() == 0) begin
                    cmp_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_resp: got %0h, required no response", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("response", mon_act, mon_exp);
                end
            end
            prev_done = bus.tx_done;
            prev_err  = bus.tx_err;
        end else begin
            prev_done = 1'b0;
            prev_err  = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int n = 0;
        while (!bus.tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tx_ready) fail("wait_ready");
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [7:0] b, input bit push, input logic [13:0] exp);
        if (push) exp_q.push_back(exp);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic check_inhibit();
        int n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, 20);
        check("rts_setup", {ps2_clk_oe, ps2_data_oe}, 2'b11);
        @(negedge clk);
        check("rts", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    endtask

    task automatic wait_resp();
        int n = 0;
        while (!(bus.tx_done || bus.tx_err) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!(bus.tx_done || bus.tx_err)) fail("wait_resp");
    endtask

    task automatic wait_dev_bits(input int b);
        int n = 0;
        while (!(dev_active && dev_bits >= b) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!(dev_active && dev_bits >= b)) fail("wait_dev_bits");
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int n;
        clrn         = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        dev_mode     = 0;
        dev_abort    = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus.tx_ready, bus.busy, ps2_clk_oe, ps2_data_oe, bus.tx_done, bus.tx_err, bus.err_code},
              8'b1000_0000);
        check("reset_state", bus.dbg_state, 3'd0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        // 0xED: 6 ones -> parity 1
        wait_ready();
        issue(8'hED, 1'b1, ok_resp(8'hED, 1'b1));
        check_inhibit();
        wait_resp();

        // 0x00 then 0x07 accepted right after the first tx_done
        wait_ready();
        issue(8'h00, 1'b1, ok_resp(8'h00, 1'b1));
        wait_resp();
        check("b2b_ready_at_done", bus.tx_ready, 1'b1);
        issue(8'h07, 1'b1, ok_resp(8'h07, 1'b0));
        check("b2b_accepted", bus.busy, 1'b1);
        check_inhibit();
        wait_resp();

        // Silent device: timeout 2000 cycles after RTS entry
        repeat (5) @(negedge clk);
        dev_mode = 1;
        wait_ready();
        issue(8'h55, 1'b1, err_resp(2'b01));
        check_inhibit();
        n = 0;
        while (!bus.tx_err && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_delay", n, 2000);
        @(negedge clk);
        check("timeout_release", {ps2_clk_oe, ps2_data_oe, bus.tx_ready}, 3'b001);
        dev_mode = 0;

        // NACK at the 11th fall
        repeat (5) @(negedge clk);
        dev_mode = 2;
        wait_ready();
        issue(8'hF0, 1'b1, err_resp(2'b10));
        wait_resp();
        check("nack_no_done", bus.tx_done, 1'b0);
        repeat (40) @(negedge clk);
        check("err_code_hold", bus.err_code, 2'b10);
        dev_mode = 0;

        // 0x81 in flight, 0xAA pulsed while busy must be ignored
        wait_ready();
        issue(8'h81, 1'b1, ok_resp(8'h81, 1'b1));
        wait_dev_bits(3);
        check("busy_in_send", bus.busy, 1'b1);
        bus.tx_data  = 8'hAA;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        wait_resp();
        repeat (40) @(negedge clk);
        check("no_requeue", {bus.tx_ready, ps2_clk_oe}, 2'b10);

        // Asynchronous reset in the middle of SEND
        wait_ready();
        issue(8'hFF, 1'b0, '0);
        wait_dev_bits(4);
        #2;
        clrn      = 1'b0;
        dev_abort = 1'b1;
        #1;
        check("async_reset_release",
              {ps2_clk_oe, ps2_data_oe, bus.tx_ready, bus.busy, bus.err_code}, 6'b001000);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        n = 0;
        while (dev_active && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (dev_active) fail("dev_abort");
        dev_abort = 1'b0;

        // Fresh 0xF3 after reset: 6 ones -> parity 1
        repeat (5) @(negedge clk);
        wait_ready();
        issue(8'hF3, 1'b1, ok_resp(8'hF3, 1'b1));
        check_inhibit();
        wait_resp();

        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter: the opposite direction of the existing ps2_keyboard receive path. It sends one command byte to the keyboard, such as 0xED set-LEDs, 0xF3 typematic or 0xFF reset, using the standard inhibit / request-to-send / device-clocked sequence. It drives the open-drain PS/2 clock and data lines through active-high pull-low enables. It exposes a busy flag so the top level can hold the receiver's nextdata_n/ready path off during a transmission.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2 clock is held low before request-to-send (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max clk cycles between consecutive device clock falling edges, or waiting for the first edge/idle (15 ms at 50 MHz)

Ports:
clk  in  1  system clock, 50 MHz
clrn  in  1  asynchronous active-low reset
ps2_clk_in  in  1  sampled ps2 clock pad
ps2_data_in  in  1  sampled ps2 data pad
ps2_clk_oe  out  1  1 = pull ps2 clock low, 0 = release
ps2_data_oe  out  1  1 = pull ps2 data low, 0 = release
tx_data  in  8  command byte
tx_valid  in  1  request; byte accepted when tx_valid && tx_ready
tx_ready  out  1  1 only in IDLE (combinational from state)
busy  out  1  ~tx_ready
tx_done  out  1  1-cycle pulse: byte acknowledged by device
tx_err  out  1  1-cycle pulse: transfer failed
err_code  out  2  valid with tx_err: 01 timeout, 10 NACK; holds last value

Behaviour:
- Reset (clrn=0, async): state=IDLE; ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, err_code=00; tx_ready=1. Lines are released immediately, including mid-transfer.
- Sync: ps2_clk_in passes through 3 flops. fall = s[2:1]==2'b10, one pulse per device falling edge, 3-cycle latency. ps2_data_in passes through 2 flops.
- Frame shift register: {stop=1, parity, tx_data[7:0]}. parity = ~^tx_data (odd parity). Loaded at accept. bit_cnt counts 0..10.
- While bit b is being presented, ps2_data_oe = ~b (open-drain).
- States and transitions:
  - IDLE: on accept, go to INHIBIT and clear the counter.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS_SETUP.
  - RTS_SETUP: 1 cycle with clk_oe=1, data_oe=1 (start bit asserted before clock release). Then go to RTS.
  - RTS: clk_oe=0, data_oe=1. On fall, present frame bit 0 and go to SEND with bit_cnt=1.
  - SEND: on fall with bit_cnt 1..9, present frame bit bit_cnt and increment. Bit 9 (stop) gives data_oe=0. On fall with bit_cnt=10, go to ACK_SAMPLE.
  - ACK_SAMPLE: sample synced data at that same fall. 0 → WAIT_IDLE. 1 → tx_err=1, err_code=10, go to IDLE.
  - WAIT_IDLE: wait until synced clock=1 and data=1. Then tx_done=1 for 1 cycle and go to IDLE.
- Timeout counter:
  - Cleared on state entry and on each fall.
  - Active in RTS, SEND and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES: release both lines, tx_err=1, err_code=01, go to IDLE.
  - If fall and timeout occur in the same cycle, fall wins.
- tx_valid while busy is ignored; it is not queued and tx_data is not re-sampled.
- A new byte may be accepted the cycle after tx_done or tx_err.
- Data changes only on device falling edges. The device samples on rising edges, so hold time is guaranteed by protocol.
- tx_done and tx_err are never asserted together.

Test Plan:
- Device bench model uses a 40-cycle clock period; INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000.
- Send 0xED → clk_oe high exactly 20 cycles, then 1 cycle with both oe=1. Model receives start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Model ACKs → tx_done pulse 1 cycle, tx_err=0, model byte=0xED.
- Send 0x00 then 0x07 back-to-back → parity bits 1 and 0 respectively. Second byte is accepted the cycle after the first tx_done.
- Model never clocks after RTS → tx_err with err_code=01 exactly 2000 cycles after RTS entry. Both oe=0 and tx_ready=1 the next cycle.
- Model returns data=1 at the 11th falling edge → tx_err, err_code=10, no tx_done.
- Pulse tx_valid with 0xAA while busy during SEND → ignored; the in-flight byte completes unchanged and only one tx_done occurs.
- Assert clrn=0 mid-SEND → ps2_clk_oe=ps2_data_oe=0 with no clock edge, tx_ready=1. A fresh 0xF3 after reset completes correctly.
